// File: rtl/ct_ifu_icache_data_array_param.sv
// Banked single-port I-cache data array: registered reads, one-entry refill write buffer
// with read-priority arbitration bounded by a starvation limit, and write-to-read forwarding.
module ct_ifu_icache_data_array_param #(
    parameter int BANKS      = 4,
    parameter int BANK_DW    = 32,
    parameter int DEPTH      = 1024,
    parameter int STARVE_MAX = 4,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int DW        = BANKS * BANK_DW,
    localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst,
    input  logic                rd_req,
    input  logic [IDX_W-1:0]    rd_index,
    input  logic [BANKS-1:0]    rd_bank_en,
    output logic                rd_gnt,
    output logic                rd_vld,
    output logic [DW-1:0]       rd_dout,
    input  logic                wr_vld,
    output logic                wr_rdy,
    input  logic [IDX_W-1:0]    wr_index,
    input  logic [BANKS-1:0]    wr_bank_mask,
    input  logic [DW-1:0]       wr_data,
    output logic                busy
);

    logic                buf_vld_reg;
    logic [IDX_W-1:0]    buf_index_reg;
    logic [BANKS-1:0]    buf_mask_reg;
    logic [DW-1:0]       buf_data_reg;
    logic [CNT_W-1:0]    starve_cnt_reg;
    logic                rd_vld_reg;

    logic force_wr;
    logic drain;
    logic accept;
    logic idx_hit;

    assign force_wr = buf_vld_reg && (starve_cnt_reg == CNT_W'(STARVE_MAX));
    assign rd_gnt   = rd_req && !force_wr;
    assign drain    = buf_vld_reg && !rd_gnt;
    assign wr_rdy   = !buf_vld_reg || drain;
    assign accept   = wr_vld && wr_rdy;
    assign idx_hit  = buf_vld_reg && (rd_index == buf_index_reg);
    assign busy     = buf_vld_reg;
    assign rd_vld   = rd_vld_reg;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            buf_vld_reg    <= 1'b0;
            starve_cnt_reg <= '0;
            rd_vld_reg     <= 1'b0;
        end else begin
            rd_vld_reg <= rd_gnt;
            if (accept) begin
                buf_vld_reg <= 1'b1;
            end else if (drain) begin
                buf_vld_reg <= 1'b0;
            end
            // Any buffered entry that is not draining has just lost to a granted read.
            if (!buf_vld_reg || drain) begin
                starve_cnt_reg <= '0;
            end else if (starve_cnt_reg != CNT_W'(STARVE_MAX)) begin
                starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Payload needs no reset: it is only consumed while buf_vld_reg is set.
    always_ff @(posedge forever_cpuclk) begin
        if (accept) begin
            buf_index_reg <= wr_index;
            buf_mask_reg  <= wr_bank_mask;
            buf_data_reg  <= wr_data;
        end
    end

    // Lane gi occupies bits [gi*BANK_DW +: BANK_DW]; mask/enable bit gi maps to the same lane,
    // so bank0 (MSB slice) is controlled by bit BANKS-1.
    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_lane
            logic [BANK_DW-1:0] mem [DEPTH];
            logic [BANK_DW-1:0] ram_q_reg;
            logic [BANK_DW-1:0] hold_reg;
            logic               ram_sel_reg;
            logic               lane_rd;
            logic               lane_fwd;
            logic               lane_we;
            logic               lane_en;
            logic [IDX_W-1:0]   lane_addr;
            logic [BANK_DW-1:0] lane_wdata;
            logic [BANK_DW-1:0] lane_dout;

            assign lane_rd    = rd_gnt && rd_bank_en[gi] && !cpurst;
            assign lane_fwd   = lane_rd && idx_hit && buf_mask_reg[gi];
            assign lane_we    = drain && buf_mask_reg[gi] && !cpurst;
            assign lane_en    = (lane_rd && !lane_fwd) || lane_we;
            assign lane_addr  = lane_we ? buf_index_reg : rd_index;
            assign lane_wdata = buf_data_reg[gi*BANK_DW +: BANK_DW];

            always_ff @(posedge forever_cpuclk) begin
                if (lane_en) begin
                    if (lane_we) begin
                        mem[lane_addr] <= lane_wdata;
                    end else begin
                        ram_q_reg <= mem[lane_addr];
                    end
                end
            end

            // hold_reg carries either the previous output or forwarded buffer data.
            always_ff @(posedge forever_cpuclk) begin
                if (cpurst) begin
                    hold_reg    <= '0;
                    ram_sel_reg <= 1'b0;
                end else begin
                    ram_sel_reg <= lane_rd && !lane_fwd;
                    hold_reg    <= lane_fwd ? lane_wdata : lane_dout;
                end
            end

            assign lane_dout = ram_sel_reg ? ram_q_reg : hold_reg;
            assign rd_dout[gi*BANK_DW +: BANK_DW] = lane_dout;
        end
    endgenerate

endmodule

// File: tb/tb_ct_ifu_icache_data_array_param.sv
// Directed bench for the banked I-cache data array: a per-cycle transaction-level model
// plus literal expectations for the key scenarios.
module tb_ct_ifu_icache_data_array_param;
    localparam int B  = 4;
    localparam int W  = 32;
    localparam int N  = 1024;
    localparam int SM = 4;

    logic           clk = 1'b0;
    logic           cpurst;
    logic           rd_req;
    logic [9:0]     rd_index;
    logic [B-1:0]   rd_bank_en;
    logic           rd_gnt;
    logic           rd_vld;
    logic [B*W-1:0] rd_dout;
    logic           wr_vld;
    logic           wr_rdy;
    logic [9:0]     wr_index;
    logic [B-1:0]   wr_bank_mask;
    logic [B*W-1:0] wr_data;
    logic           busy;

    int total = 0;
    int bad   = 0;

    ct_ifu_icache_data_array_param #(
        .BANKS(B), .BANK_DW(W), .DEPTH(N), .STARVE_MAX(SM)
    ) dut (
        .forever_cpuclk(clk), .cpurst(cpurst),
        .rd_req(rd_req), .rd_index(rd_index), .rd_bank_en(rd_bank_en),
        .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_dout(rd_dout),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_index(wr_index),
        .wr_bank_mask(wr_bank_mask), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model, indexed by bank number (bank0 = most significant slice).
    bit [W-1:0]   mem [N][B];
    bit           mem_known [N][B];
    bit           m_armed = 0;
    bit           m_buf_vld;
    int           m_buf_idx;
    bit [B-1:0]   m_buf_mask;
    bit [B*W-1:0] m_buf_data;
    int           m_lost;
    bit           m_rd_vld;
    bit [W-1:0]   m_dout [B];
    bit           m_known [B];
    bit           e_gnt, e_drain, e_wrdy;

    function automatic bit [W-1:0] slice(input bit [B*W-1:0] v, input int b);
        return v[(B-b)*W-1 -: W];
    endfunction

    always @(negedge clk) begin
        e_gnt   = rd_req && !(m_buf_vld && m_lost >= SM);
        e_drain = m_buf_vld && !e_gnt;
        e_wrdy  = !m_buf_vld || e_drain;
        if (m_armed) begin
            chk("rd_gnt", rd_gnt, e_gnt);
            chk("wr_rdy", wr_rdy, e_wrdy);
            chk("busy", busy, m_buf_vld);
            chk("rd_vld", rd_vld, m_rd_vld);
            for (int b = 0; b < B; b++)
                if (m_known[b]) chk($sformatf("rd_dout_bank%0d", b), slice(rd_dout, b), m_dout[b]);
        end
        if (cpurst) begin
            m_armed = 1; m_buf_vld = 0; m_lost = 0; m_rd_vld = 0;
            for (int b = 0; b < B; b++) begin m_dout[b] = '0; m_known[b] = 1; end
        end else if (m_armed) begin
            m_rd_vld = e_gnt;
            if (e_gnt) begin
                for (int b = 0; b < B; b++) begin
                    if (rd_bank_en[B-1-b]) begin
                        if (m_buf_vld && m_buf_idx == int'(rd_index) && m_buf_mask[B-1-b]) begin
                            m_dout[b] = slice(m_buf_data, b); m_known[b] = 1;
                        end else begin
                            m_dout[b] = mem[rd_index][b]; m_known[b] = mem_known[rd_index][b];
                        end
                    end
                end
                if (m_buf_vld) m_lost++;
            end
            if (e_drain) begin
                for (int b = 0; b < B; b++)
                    if (m_buf_mask[B-1-b]) begin
                        mem[m_buf_idx][b] = slice(m_buf_data, b);
                        mem_known[m_buf_idx][b] = 1;
                    end
                m_buf_vld = 0;
            end
            if (wr_vld && e_wrdy) begin
                m_buf_vld = 1; m_buf_idx = int'(wr_index); m_buf_mask = wr_bank_mask;
                m_buf_data = wr_data; m_lost = 0;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rq, input logic [9:0] ri, input logic [3:0] ren,
                          input logic wv, input logic [9:0] wi, input logic [3:0] wm,
                          input logic [127:0] wd);
        rd_req = rq; rd_index = ri; rd_bank_en = ren;
        wr_vld = wv; wr_index = wi; wr_bank_mask = wm; wr_data = wd;
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, '0);
    endtask

    function automatic logic [127:0] bdata(input int i);
        return {32'h1000_0000 + i, 32'h2000_0000 + i, 32'h3000_0000 + i, 32'h4000_0000 + i};
    endfunction

    localparam logic [127:0] D1 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] O9 = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
    localparam logic [127:0] P9 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] S  = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] XA = 128'hCAFE0003_CAFE1003_CAFE2003_CAFE3003;
    localparam logic [127:0] YA = 128'hBEEF0004_BEEF1004_BEEF2004_BEEF3004;
    localparam logic [127:0] A7 = 128'h77770000_77771111_77772222_77773333;
    localparam logic [127:0] B7 = 128'h88880000_88881111_88882222_88883333;

    initial begin
        logic [127:0] exp_v;
        cpurst = 1;
        idle();
        next(); next();
        cpurst = 0;
        idle();
        chk("reset_busy", busy, 0);
        chk("reset_rd_vld", rd_vld, 0);
        chk("reset_rd_dout", rd_dout, '0);
        chk("reset_wr_rdy", wr_rdy, 1);

        // Idle write then read
        set_in(0, 0, 0, 1, 5, 4'hF, D1); next();
        idle(); next();
        set_in(1, 5, 4'hF, 0, 0, 0, '0);
        chk("t1_gnt", rd_gnt, 1); next();
        idle();
        chk("t1_vld", rd_vld, 1);
        chk("t1_data", rd_dout, D1); next();
        chk("t1_vld_off", rd_vld, 0);

        // Forwarding of a partial-mask buffered write
        set_in(0, 0, 0, 1, 9, 4'hF, O9); next();
        idle(); next();
        set_in(1, 5, 4'hF, 1, 9, 4'b0101, P9); next();
        set_in(1, 9, 4'hF, 0, 0, 0, '0); next();
        set_in(1, 5, 4'hF, 0, 0, 0, '0);
        chk("t2_fwd", rd_dout, 128'hAAAA0000_89ABCDEF_CCCC2222_76543210);
        for (int k = 0; k < 20 && busy; k++) next();
        chk("t2_drain_timeout", busy, 0);
        idle(); next();

        // Starvation bound under continuous reads
        set_in(1, 5, 4'hF, 1, 12, 4'hF, S);
        chk("t3_gnt_c0", rd_gnt, 1); next();
        for (int k = 1; k <= 6; k++) begin
            set_in(1, 5, 4'hF, 0, 0, 0, '0);
            chk($sformatf("t3_gnt_c%0d", k), rd_gnt, (k == 5) ? 1'b0 : 1'b1);
            chk($sformatf("t3_busy_c%0d", k), busy, (k <= 5) ? 1'b1 : 1'b0);
            next();
        end
        set_in(1, 12, 4'hF, 0, 0, 0, '0); next();
        idle();
        chk("t3_readback", rd_dout, S); next();

        // Back-to-back writes, then pipelined readback
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, 1, 10'(100 + i), 4'hF, bdata(i));
            chk($sformatf("t4_wr_rdy%0d", i), wr_rdy, 1); next();
        end
        set_in(0, 0, 0, 1, 100, 4'h0, 128'hDEAD);   // all-zero mask: no array update
        next();
        idle(); next();
        set_in(1, 100, 4'hF, 0, 0, 0, '0); next();
        for (int i = 1; i <= 8; i++) begin
            if (i < 8) set_in(1, 10'(100 + i), 4'hF, 0, 0, 0, '0);
            else idle();
            chk($sformatf("t4_rd%0d", i - 1), rd_dout, bdata(i - 1));
            next();
        end

        // Partial read enable, then all-zero enable
        set_in(0, 0, 0, 1, 3, 4'hF, XA); next();
        set_in(0, 0, 0, 1, 4, 4'hF, YA); next();
        idle(); next();
        set_in(1, 4, 4'hF, 0, 0, 0, '0); next();
        set_in(1, 3, 4'b1000, 0, 0, 0, '0); next();
        set_in(1, 3, 4'b0000, 0, 0, 0, '0);
        exp_v = {XA[127:96], YA[95:0]};
        chk("t5_partial", rd_dout, exp_v); next();
        idle();
        chk("t5_zero_en_vld", rd_vld, 1);
        chk("t5_zero_en_hold", rd_dout, exp_v); next();

        // Reset while a write is buffered drops it
        set_in(0, 0, 0, 1, 7, 4'hF, A7); next();
        idle(); next();
        set_in(1, 5, 4'hF, 1, 7, 4'hF, B7); next();
        set_in(1, 5, 4'hF, 0, 0, 0, '0);
        chk("t6_busy_pre", busy, 1);
        cpurst = 1; next();
        cpurst = 0;
        idle();
        chk("t6_busy", busy, 0);
        chk("t6_rd_vld", rd_vld, 0);
        chk("t6_rd_dout", rd_dout, '0); next();
        set_in(1, 7, 4'hF, 0, 0, 0, '0); next();
        idle();
        chk("t6_old_data", rd_dout, A7); next();
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
